request_latch: RTL
==================

// Module: request_latch
// PURPOSE
//  Receive end for synchronized external requests (pedestrian buttons, vehicle loops).
//  Takes a 1-bit input already synchronized into clk, debounces it and captures each press
//  as a request. The request holds until the traffic controller FSM acknowledges it.
//  Also keeps a saturating press counter for diagnostics.
//  One instance per request input, placed between the input synchronizer and the controller.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive differing samples needed to flip the debounced level (>=2)
//  CNT_W            8   width of press_count_o; the counter saturates at 2**CNT_W-1
// PORTS
//  clk            in   1      system clock; all state updates on the rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  sync_in        in   1      request level, already synchronized to clk
//  ack_i          in   1      1-cycle acknowledge from controller; retires pending request
//  count_clr_i    in   1      synchronous clear of press_count_o
//  level_o        out  1      debounced level of sync_in
//  req_o          out  1      request pending (registered; high exactly while state==PENDING)
//  press_count_o  out  CNT_W  number of debounced rising edges since reset or clear
// BEHAVIOUR
//  Reset: while rst_n=0, immediately force level_o=0, req_o=0, press_count_o=0,
//   debounce counter=0, state=IDLE. Reset applies asynchronously at any point, including mid-debounce or PENDING.
//  Debounce (each edge):
//   - sync_in==level: clear the debounce counter.
//   - sync_in!=level and counter==DEBOUNCE_CYCLES-1: toggle level and clear the counter.
//   - otherwise: increment the counter.
//   So level_o follows a stable change on the DEBOUNCE_CYCLES-th consecutive differing sample.
//   A shorter glitch leaves level_o unchanged.
//  rise = level toggled 0->1 on this edge (registered 1-cycle strobe, internal).
//  FSM (3 states, transitions on clk edge after rise is seen):
//   IDLE:     rise -> PENDING; ack_i ignored.
//   PENDING:  ack_i=1 -> WAIT_REL if level=1, else IDLE.
//             A rise with no ack (release and re-press) merges into the current request: no new request.
//             ack_i and rise in the same cycle: ack wins -> WAIT_REL.
//   WAIT_REL: level=0 -> IDLE. A rise here is impossible by construction; ack_i is ignored.
//   Held button -> exactly one request per press; re-arm requires a debounced release.
//  req_o = (state==PENDING), registered. Latency from the first differing sample of a clean press
//   to req_o=1 is DEBOUNCE_CYCLES+1 edges. The request drops on the edge that samples ack_i=1.
//  press_count_o: +1 on every rise, in every state, saturating at all-ones.
//   count_clr_i has priority: clear together with a rise in the same cycle gives 0.
//  Unused encodings of the state register return to IDLE.
//  Input held high across reset release: level rises after DEBOUNCE_CYCLES samples and
//   raises one request (intended: a press during reset is not lost).
// STRUCTURE
//  Shared include tc_defs.vh holds the FSM encodings (RL_IDLE=2'd0, RL_PENDING=2'd1,
//   RL_WAIT_REL=2'd2) and the default DEBOUNCE_CYCLES used across the traffic controller.
//  Sub-module debounce_filter(clk, rst_n, in, level, rise), parameterised by DEBOUNCE_CYCLES.
//   Counter width is clog2(DEBOUNCE_CYCLES). request_latch holds the FSM and the press counter.
// TESTING (DEBOUNCE_CYCLES=4, CNT_W=8)
//  1 Clean press: sync_in 0->1 held 20 cycles, no ack
//    -> level_o=1 after the 4th high sample; req_o=1 one edge later and stays high; count=1.
//  2 Glitches: 3-cycle high pulse, then 1-cycle pulses every other cycle for 20 cycles
//    -> level_o, req_o and count stay 0.
//  3 Ack while held: pending request, ack_i 1 cycle while sync_in is still high
//    -> req_o=0 the next cycle. A further 50 held cycles raise no new req.
//    After release (4 low samples) and re-press: req_o rises again; count=2.
//  4 Merge, then simultaneous events: pending request; release/re-press with no ack
//    -> req_o stays 1, count +1.
//    Then drive ack_i and count_clr_i on the rise cycle of a 3rd press
//    -> state WAIT_REL, count=0.
//  5 Saturation: 300 clean press/release cycles, each acked -> press_count_o stops at 255.
//  6 Async reset mid-PENDING: drop rst_n between edges -> outputs 0 before the next edge.
//    Release with sync_in=1 -> req_o=1 at DEBOUNCE_CYCLES+1 edges after release.

Source files
------------

// File: rtl/request_latch_pkg.sv
// Shared definitions for the request latch: FSM encodings, default debounce
// length and the request FSM next-state function.
package request_latch_pkg;

  // Debounce length used across the traffic controller unless overridden.
  localparam int RL_DEBOUNCE_CYCLES_DEFAULT = 4;

  // Request FSM encodings (2'd3 is unused and recovers to RL_IDLE).
  typedef enum logic [1:0] {
    RL_IDLE     = 2'd0,
    RL_PENDING  = 2'd1,
    RL_WAIT_REL = 2'd2
  } rl_state_e;

  // Next state of the request FSM.
  // An ack in PENDING beats a simultaneous rise: the request is retired and
  // the FSM waits for a debounced release before it can re-arm.
  function automatic rl_state_e rl_next_state(input rl_state_e st,
                                              input logic      rise,
                                              input logic      ack,
                                              input logic      level);
    rl_state_e nxt;
    nxt = RL_IDLE;
    case (st)
      RL_IDLE: begin
        if (rise) begin
          nxt = RL_PENDING;
        end else begin
          nxt = RL_IDLE;
        end
      end
      RL_PENDING: begin
        if (ack) begin
          if (level) begin
            nxt = RL_WAIT_REL;
          end else begin
            nxt = RL_IDLE;
          end
        end else begin
          // A release/re-press without ack merges into the current request.
          nxt = RL_PENDING;
        end
      end
      RL_WAIT_REL: begin
        if (!level) begin
          nxt = RL_IDLE;
        end else begin
          nxt = RL_WAIT_REL;
        end
      end
      default: begin
        nxt = RL_IDLE;
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/request_latch_debounce_filter.sv
// Debounce filter: the registered level flips only after DEBOUNCE_CYCLES
// consecutive samples that differ from it; rise is a registered one-cycle
// strobe marking a 0->1 flip of the level.
module debounce_filter
  import request_latch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = RL_DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;
  logic          rise_q;
  logic          rise_d;

  // Next debounce counter, level and rise strobe from the current sample.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (in == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    rise_d = level_d & ~level_q;
  end

  // Debounce state registers; reset forces a low, quiet level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/request_latch.sv
// Request latch: debounces a synchronized request input, holds one request
// per debounced press until the controller acknowledges it, and counts
// presses in a saturating diagnostic counter.
module request_latch
  import request_latch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = RL_DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_in,
  input  logic             ack_i,
  input  logic             count_clr_i,
  output logic             level_o,
  output logic             req_o,
  output logic [CNT_W-1:0] press_count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             level_s;
  logic             rise_s;
  rl_state_e        state_q;
  rl_state_e        state_d;
  logic             req_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (sync_in),
    .level (level_s),
    .rise  (rise_s)
  );

  // FSM next state, shared by the state register and the registered req_o.
  always_comb begin
    state_d = rl_next_state(state_q, rise_s, ack_i, level_s);
  end

  // Request FSM; req_q is registered from the next state so it is high
  // exactly while the state register holds PENDING.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RL_IDLE;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == RL_PENDING);
    end
  end

  // Saturating press counter; clear takes priority over a same-cycle rise.
  always_comb begin
    count_d = count_q;
    if (count_clr_i) begin
      count_d = '0;
    end else if (rise_s && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Press counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign level_o       = level_s;
  assign req_o         = req_q;
  assign press_count_o = count_q;

endmodule
